pipe_hazard_ctrl: RTL and testbench

- Responder side of the hazard/forwarding stall protocol in the 5-stage rv32i pipeline.
- Consumes the forwarding unit's load-use stall request, branch-redirect requests from EX, and the imem/dmem handshake status.
- Produces per-stage register write enables, bubble/flush controls and an in-flight-fetch discard.
- Owns the only sequential hazard state in the pipeline: the stale-fetch discard FSM and the stall accounting.

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: requests/handshake status in, stage controls and perf counters out.
// master drives hazard requests and memory status; slave is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             forward_stall;
  logic             br_flush;
  logic             mem_access;
  logic             dmem_resp;
  logic             imem_inflight;
  logic             imem_resp;
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             imem_discard;
  logic             discard_pending;
  logic [CNT_W-1:0] perf_dmem;
  logic [CNT_W-1:0] perf_imem;
  logic [CNT_W-1:0] perf_lu;
  logic [CNT_W-1:0] perf_flush;

  modport master (
    output forward_stall, br_flush, mem_access, dmem_resp, imem_inflight, imem_resp,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
    input  imem_discard, discard_pending, perf_dmem, perf_imem, perf_lu, perf_flush
  );

  modport slave (
    input  forward_stall, br_flush, mem_access, dmem_resp, imem_inflight, imem_resp,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
    output imem_discard, discard_pending, perf_dmem, perf_imem, perf_lu, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall responder for the 5-stage rv32i pipeline: stage enables, bubbles, stale-fetch discard.
// Saturating stall/flush counters exist only with PIPE_HAZARD_CTRL_PERF_EN; otherwise perf_* read 0.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN = 1'b0, DISCARD = 1'b1} state_t;

  state_t state_q, state_d;
  logic   frozen, imem_wait, in_disc, drop_resp;
  logic   pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic   if_id_flush, id_ex_flush, imem_discard;

  assign frozen    = hz.mem_access && !hz.dmem_resp;
  assign imem_wait = hz.imem_inflight && !hz.imem_resp;
  assign in_disc   = (state_q == DISCARD);
  assign drop_resp = in_disc && hz.imem_resp;

  always_comb begin
    state_d      = state_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    imem_discard = 1'b0;
    if (frozen) begin
      // whole pipeline holds; only the stale-response drop below may act
    end else if (hz.br_flush) begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (!in_disc && imem_wait)     state_d = DISCARD;
      if (!in_disc && hz.imem_resp)  imem_discard = 1'b1;
    end else if (hz.forward_stall || imem_wait || in_disc) begin
      id_ex_we    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
    end else begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
    end
    // The fetch that was outstanding at redirect returns: consume and drop it.
    if (drop_resp) begin
      imem_discard = 1'b1;
      if_id_we     = 1'b0;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign hz.pc_we           = rst_n & pc_we;
  assign hz.if_id_we        = rst_n & if_id_we;
  assign hz.id_ex_we        = rst_n & id_ex_we;
  assign hz.ex_mem_we       = rst_n & ex_mem_we;
  assign hz.mem_wb_we       = rst_n & mem_wb_we;
  assign hz.if_id_flush     = rst_n & if_id_flush;
  assign hz.id_ex_flush     = rst_n & id_ex_flush;
  assign hz.imem_discard    = rst_n & imem_discard;
  assign hz.discard_pending = rst_n & in_disc;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic             inc_dmem, inc_flush, inc_lu, inc_imem;
  logic [CNT_W-1:0] perf_dmem_q, perf_dmem_d, perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_lu_q, perf_lu_d, perf_imem_q, perf_imem_d;

  // One cause per cycle, same priority order as the control decode.
  always_comb begin
    inc_dmem     = frozen;
    inc_flush    = !frozen && hz.br_flush;
    inc_lu       = !frozen && !hz.br_flush && hz.forward_stall;
    inc_imem     = !frozen && !hz.br_flush && !hz.forward_stall && (imem_wait || in_disc);
    perf_dmem_d  = perf_dmem_q;
    perf_flush_d = perf_flush_q;
    perf_lu_d    = perf_lu_q;
    perf_imem_d  = perf_imem_q;
    if (inc_dmem  && perf_dmem_q  != '1) perf_dmem_d  = perf_dmem_q  + ONE;
    if (inc_flush && perf_flush_q != '1) perf_flush_d = perf_flush_q + ONE;
    if (inc_lu    && perf_lu_q    != '1) perf_lu_d    = perf_lu_q    + ONE;
    if (inc_imem  && perf_imem_q  != '1) perf_imem_d  = perf_imem_q  + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dmem_q  <= '0;
      perf_flush_q <= '0;
      perf_lu_q    <= '0;
      perf_imem_q  <= '0;
    end else begin
      perf_dmem_q  <= perf_dmem_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
      perf_imem_q  <= perf_imem_d;
    end
  end

  assign hz.perf_dmem  = perf_dmem_q;
  assign hz.perf_flush = perf_flush_q;
  assign hz.perf_lu    = perf_lu_q;
  assign hz.perf_imem  = perf_imem_q;
`else
  assign hz.perf_dmem  = '0;
  assign hz.perf_flush = '0;
  assign hz.perf_lu    = '0;
  assign hz.perf_imem  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cause-table model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, imem_discard, discard_pending}
  localparam logic [8:0] V_RUN   = 9'b11111_00_0_0;
  localparam logic [8:0] V_ZERO  = 9'b00000_00_0_0;
  localparam logic [8:0] V_BR    = 9'b11111_11_0_0;
  localparam logic [8:0] V_STALL = 9'b00111_01_0_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  function automatic logic [8:0] ctl();
    return {hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we,
            hz.if_id_flush, hz.id_ex_flush, hz.imem_discard, hz.discard_pending};
  endfunction

  function automatic logic [CNT_W-1:0] ec(input int n);
    return PERF ? CNT_W'(n) : '0;
  endfunction

  task automatic drive(input logic fs, br, ma, dr, inf, rsp);
    hz.forward_stall = fs;
    hz.br_flush      = br;
    hz.mem_access    = ma;
    hz.dmem_resp     = dr;
    hz.imem_inflight = inf;
    hz.imem_resp     = rsp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference: classify the cycle by its single winning cause, then read outputs from that cause.
  // cause: 0 dmem freeze, 1 branch, 2 load-use, 3 imem wait/discard, 4 none
  function automatic logic [8:0] model(input bit disc, input logic fs, br, ma, dr, inf, rsp,
                                       output int cause, output bit nxt);
    logic [6:0] tbl [5];
    logic [8:0] v;
    tbl[0] = 7'b00000_00;
    tbl[1] = 7'b11111_11;
    tbl[2] = 7'b00111_01;
    tbl[3] = 7'b00111_01;
    tbl[4] = 7'b11111_00;
    if (ma && !dr)                  cause = 0;
    else if (br)                    cause = 1;
    else if (fs)                    cause = 2;
    else if ((inf && !rsp) || disc) cause = 3;
    else                            cause = 4;
    v   = {tbl[cause], 1'b0, disc};
    nxt = disc;
    if (cause == 1 && !disc && rsp)         v[1] = 1'b1;
    if (cause == 1 && !disc && inf && !rsp) nxt = 1'b1;
    if (disc && rsp) begin
      v[1] = 1'b1;
      v[7] = 1'b0;
      nxt  = 1'b0;
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_ZERO) begin errors++; $display("FAIL reset_outputs: got %b expected %b", ctl(), V_ZERO); end
    do_reset();
    drive(0, 1, 0, 0, 1, 0);
    #3;
    checks++;
    if (ctl() !== V_BR) begin errors++; $display("FAIL reset_pre_branch: got %b expected %b", ctl(), V_BR); end
    tick();
    drive(0, 0, 0, 0, 1, 0);
    #3;
    checks++;
    if (hz.discard_pending !== 1'b1) begin errors++; $display("FAIL reset_enter_discard: got %b expected 1", hz.discard_pending); end
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_ZERO) begin errors++; $display("FAIL reset_mid_discard: got %b expected %b", ctl(), V_ZERO); end
    tick();
    rst_n = 1'b1;
    #3;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL reset_release: got %b expected %b", ctl(), V_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_STALL) begin errors++; $display("FAIL lu_ctl: got %b expected %b", ctl(), V_STALL); end
    checks++;
    if (hz.perf_lu !== ec(0)) begin errors++; $display("FAIL lu_cnt_before: got %0d expected 0", hz.perf_lu); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL lu_after: got %b expected %b", ctl(), V_RUN); end
    checks++;
    if (hz.perf_lu !== ec(1)) begin errors++; $display("FAIL lu_cnt_after: got %0d expected %0d", hz.perf_lu, ec(1)); end
  endtask

  task automatic test_branch_discard();
    do_reset();
    drive(0, 1, 0, 0, 1, 0);
    #3;
    checks++;
    if (ctl() !== V_BR) begin errors++; $display("FAIL br_ctl: got %b expected %b", ctl(), V_BR); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      drive(0, 0, 0, 0, 1, 0);
      #3;
      checks++;
      if (ctl() !== (V_STALL | 9'b1)) begin errors++; $display("FAIL br_wait%0d: got %b expected %b", c, ctl(), V_STALL | 9'b1); end
    end
    tick();
    drive(0, 0, 0, 0, 1, 1);
    #3;
    checks++;
    if (ctl() !== (V_STALL | 9'b11)) begin errors++; $display("FAIL br_drop: got %b expected %b", ctl(), V_STALL | 9'b11); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL br_resume: got %b expected %b", ctl(), V_RUN); end
    checks++;
    if (hz.perf_flush !== ec(1) || hz.perf_imem !== ec(3)) begin
      errors++; $display("FAIL br_cnt: got flush=%0d imem=%0d expected %0d/%0d", hz.perf_flush, hz.perf_imem, ec(1), ec(3));
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 0, 0, 0);
      #3;
      checks++;
      if (ctl() !== V_ZERO) begin errors++; $display("FAIL frz_ctl%0d: got %b expected %b", c, ctl(), V_ZERO); end
      tick();
    end
    drive(1, 1, 1, 1, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_BR) begin errors++; $display("FAIL frz_release: got %b expected %b", ctl(), V_BR); end
    checks++;
    if (hz.perf_dmem !== ec(4)) begin errors++; $display("FAIL frz_dmem_cnt: got %0d expected %0d", hz.perf_dmem, ec(4)); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (hz.perf_flush !== ec(1) || hz.perf_lu !== ec(0) || hz.perf_dmem !== ec(4)) begin
      errors++; $display("FAIL frz_cnts: got flush=%0d lu=%0d dmem=%0d", hz.perf_flush, hz.perf_lu, hz.perf_dmem);
    end
  endtask

  task automatic test_discard_freeze();
    do_reset();
    drive(0, 1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0, 1, 1);
    #3;
    checks++;
    if (ctl() !== 9'b00000_00_1_1) begin errors++; $display("FAIL dfrz_ctl: got %b expected 000000011", ctl()); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL dfrz_exit: got %b expected %b", ctl(), V_RUN); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    repeat (20) tick();
    #3;
    checks++;
    if (hz.perf_dmem !== ec(SAT)) begin errors++; $display("FAIL sat_dmem: got %0d expected %0d", hz.perf_dmem, ec(SAT)); end
  endtask

  task automatic test_random();
    bit         disc = 1'b0;
    bit         nxt;
    int         cause;
    int         cnt [4];
    logic [8:0] exp_v;
    logic       fs, br, ma, dr, inf, rsp;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fs  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      ma  = ($urandom_range(0, 2) == 0);
      dr  = $urandom_range(0, 1);
      inf = $urandom_range(0, 1);
      rsp = ($urandom_range(0, 2) == 0);
      drive(fs, br, ma, dr, inf, rsp);
      #3;
      exp_v = model(disc, fs, br, ma, dr, inf, rsp, cause, nxt);
      checks++;
      if (ctl() !== exp_v) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, ctl(), exp_v); end
      checks++;
      if (hz.perf_dmem !== ec(cnt[0]) || hz.perf_flush !== ec(cnt[1]) ||
          hz.perf_lu !== ec(cnt[2]) || hz.perf_imem !== ec(cnt[3])) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                 hz.perf_dmem, hz.perf_flush, hz.perf_lu, hz.perf_imem,
                 ec(cnt[0]), ec(cnt[1]), ec(cnt[2]), ec(cnt[3]));
      end
      if (cause < 4 && cnt[cause] < SAT) cnt[cause]++;
      disc = nxt;
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_branch_discard();
    test_freeze();
    test_discard_freeze();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
